au_share_arbiter: RTL and testbench

- Round-robin arbiter that shares the single multi-cycle arithmetic datapath (R1–R5 registers, AU1/AU2, shift stage) between NREQ requesters.
- Holds a one-hot grant to steer operand muxes, issues a one-cycle start pulse to the datapath sequencer and waits for its done.
- Returns a one-cycle response tagged with the requester index.
- Sits between client blocks and the existing datapath control unit; one transaction in flight at a time.

---
 rtl/au_arb_pkg.sv | 23 ++
 rtl/au_share_arbiter_rr_pick.sv | 33 +++
 rtl/au_share_arbiter.sv | 127 ++++++++++++
 tb/tb_au_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_arb_pkg.sv
// au_arb_pkg: state encoding, AU op codes and defaults shared by
// the AU datapath arbiter and the datapath control unit.
package au_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] AU_OP_ADD = 2'd0;
  localparam logic [1:0] AU_OP_SUB = 2'd1;
  localparam logic [1:0] AU_OP_MUL = 2'd2;
  localparam logic [1:0] AU_OP_SHF = 2'd3;

  localparam int DEF_TIMEOUT = 16;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/au_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; searches upward from
// ptr+1 with wrap and returns one-hot grant, index and any-request.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic hit;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!hit && req[j] &&
            j == (int'(ptr) + k) % NREQ) begin
          hit    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDW'(j);
        end
      end
    end
    any = hit;
  end

endmodule

// File: rtl/au_share_arbiter.sv
// au_share_arbiter: round-robin owner of the shared AU datapath.
// Define AU_ARB_TIMEOUT_EN to enable the WAIT watchdog abort.
module au_share_arbiter
  import au_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        op_sel,
  output logic              dp_start,
  input  logic              dp_done,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic              busy
);

  arb_state_e      state;
  arb_state_e      nxt;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [1:0]      pick_op;
  logic            tmo;
  logic            err_nxt;

  if (IDW != idx_width(NREQ) || NREQ < 2 ||
      NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("au_share_arbiter: bad NREQ/IDW/TIMEOUT");
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_op = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_gnt[j]) pick_op = req_op[2*j +: 2];
    end
  end

`ifdef AU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts completed WAIT cycles, so this is the last allowed one
  assign tmo = (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    err_nxt = 1'b0;
    unique case (state)
      IDLE:  if (pick_any) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (dp_done) begin
          nxt = RESP;
        end else if (tmo) begin
          nxt     = RESP;
          err_nxt = 1'b1;
        end
      end
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      gnt       <= '0;
      op_sel    <= '0;
      dp_start  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt;
      dp_start  <= (state == ISSUE);
      rsp_valid <= (nxt == RESP);
      rsp_err   <= err_nxt;
      busy      <= (nxt != IDLE);
      if (state == IDLE && pick_any) begin
        gnt    <= pick_gnt;
        op_sel <= pick_op;
        rsp_id <= pick_idx;
      end
      if (state == RESP) begin
        gnt    <= '0;
        op_sel <= '0;
        ptr    <= rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_au_share_arbiter.sv
// tb_au_share_arbiter: scoreboard bench for au_share_arbiter with
// a queue-based round-robin reference model.
module tb_au_share_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              clear;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        op_sel;
  logic              dp_start;
  logic              dp_done;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  au_share_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .req       (req),
    .req_op    (req_op),
    .gnt       (gnt),
    .op_sel    (op_sel),
    .dp_start  (dp_start),
    .dp_done   (dp_done),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic [1:0] op;
    logic       err;
  } exp_t;

  exp_t            q[$];
  int              total = 0;
  int              bad = 0;
  int              ptr_m;
  logic [NREQ-1:0] pend;
  logic [1:0]      opm[NREQ];
  bit              done_ok;
  bit              prev_start = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // First pending requester strictly after p, wrapping round.
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic issue(output int w, input logic err);
    w = pick(pend, ptr_m);
    q.push_back('{w, opm[w], err});
    ptr_m = w;
    req = pend;
    for (int i = 0; i < NREQ; i++) req_op[2*i +: 2] = opm[i];
    done_ok = 1'b0;
  endtask

  task automatic wait_start(input bit noise);
    int n;
    n = 0;
    while (!dp_start && n < 8) begin
      if (noise) dp_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    dp_done = 1'b0;
    chk("start_seen", int'(dp_start), 1);
  endtask

  task automatic serve(input int dly, input bit tog);
    int n;
    wait_start(1'b1);
    for (int c = 0; c < dly; c++) begin
      if (tog) begin
        req    = NREQ'($urandom);
        req_op = (2*NREQ)'($urandom);
      end
      @(negedge clk);
    end
    dp_done = 1'b1;
    done_ok = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_seen", int'(rsp_valid), 1);
    #2;
  endtask

  always @(negedge clk) begin
    if (clear) begin
      if (dp_start) begin
        chk("start_pulse", int'(prev_start), 0);
        chk("start_q", q.size(), 1);
        if (q.size() > 0) begin
          chk("start_gnt", int'(gnt), 1 << q[0].id);
          chk("start_op", int'(op_sel), int'(q[0].op));
        end
      end
      if (rsp_valid) begin
        chk("rsp_q", q.size(), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", int'(rsp_id), e.id);
          chk("rsp_err", int'(rsp_err), int'(e.err));
          chk("rsp_gnt", int'(gnt), 1 << e.id);
          chk("rsp_op", int'(op_sel), int'(e.op));
          chk("rsp_after_done", int'(done_ok), 1);
          done_ok = 1'b0;
        end
      end
    end
    prev_start = clear ? dp_start : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    clear   = 1'b0;
    req     = '0;
    req_op  = '0;
    dp_done = 1'b0;
    pend    = '0;
    ptr_m   = NREQ - 1;
    done_ok = 1'b0;
    for (int i = 0; i < NREQ; i++) opm[i] = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_op", int'(op_sel), 0);
    chk("rst_start", int'(dp_start), 0);
    chk("rst_rsp", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_err", int'(rsp_err), 0);
    chk("rst_busy", int'(busy), 0);
    clear = 1'b1;
    @(negedge clk);

    // Directed latency transaction: requester 0, op 2'b10.
    pend   = 2'b01;
    opm[0] = 2'b10;
    issue(w, 1'b0);
    @(negedge clk);
    chk("c1_gnt", int'(gnt), 1);
    chk("c1_op", int'(op_sel), 2);
    chk("c1_start", int'(dp_start), 0);
    chk("c1_busy", int'(busy), 1);
    @(negedge clk);
    chk("c2_start", int'(dp_start), 1);
    @(negedge clk);
    chk("c3_start", int'(dp_start), 0);
    @(negedge clk);
    @(negedge clk);
    dp_done = 1'b1;
    done_ok = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    chk("c6_rsp", int'(rsp_valid), 1);
    chk("c6_busy", int'(busy), 1);
    pend = '0;
    req  = '0;
    @(negedge clk);
    chk("c7_busy", int'(busy), 0);
    chk("c7_gnt", int'(gnt), 0);
    chk("c7_op", int'(op_sel), 0);
    chk("c7_rsp", int'(rsp_valid), 0);

    // dp_done while idle must be ignored.
    dp_done = 1'b1;
    repeat (2) @(negedge clk);
    dp_done = 1'b0;
    chk("idle_done_busy", int'(busy), 0);
    chk("idle_done_rsp", int'(rsp_valid), 0);

    // Reset in the middle of WAIT.
    pend   = 2'b10;
    opm[1] = 2'($urandom);
    issue(w, 1'b0);
    wait_start(1'b0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_op", int'(op_sel), 0);
    chk("mid_rst_start", int'(dp_start), 0);
    chk("mid_rst_rsp", int'(rsp_valid), 0);
    chk("mid_rst_id", int'(rsp_id), 0);
    chk("mid_rst_err", int'(rsp_err), 0);
    chk("mid_rst_busy", int'(busy), 0);
    q.delete();
    ptr_m = NREQ - 1;
    pend  = '0;
    req   = '0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);

    // Both requesting continuously: strict alternation.
    pend = 2'b11;
    for (int i = 0; i < NREQ; i++) opm[i] = 2'($urandom);
    for (int r = 0; r < 5; r++) begin
      issue(w, 1'b0);
      serve(3, 1'b0);
    end

    // Random traffic, random WAIT length, req noise during WAIT.
    for (int r = 0; r < 60; r++) begin
      logic [NREQ-1:0] nw;
      pend[w] = 1'b0;
      nw = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (nw[i] && !pend[i]) opm[i] = 2'($urandom);
      end
      pend = pend | nw;
      if (pend == '0) begin
        n = $urandom_range(0, NREQ - 1);
        pend[n] = 1'b1;
        opm[n]  = 2'($urandom);
      end
      issue(w, 1'b0);
      serve($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    pend = '0;
    req  = '0;
    repeat (2) @(negedge clk);

`ifdef AU_ARB_TIMEOUT_EN
    // Watchdog abort after TMO WAIT cycles.
    pend   = 2'b01;
    opm[0] = 2'($urandom);
    issue(w, 1'b1);
    done_ok = 1'b1;
    wait_start(1'b0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_lat", n, TMO + 1);
    #2;
    pend = '0;
    req  = '0;
    repeat (2) @(negedge clk);

    // dp_done on the last WAIT cycle beats the watchdog.
    pend   = 2'b01;
    opm[0] = 2'($urandom);
    issue(w, 1'b0);
    wait_start(1'b0);
    repeat (TMO - 1) @(negedge clk);
    dp_done = 1'b1;
    done_ok = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    chk("tmo_done_wins", int'(rsp_valid), 1);
    #2;
    pend = '0;
    req  = '0;
    repeat (2) @(negedge clk);
`endif

    chk("final_q", q.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
